muladd: RTL
===========

MULADD -- requirements
Module: muladd

Interface
REQ-001 SHALL have parameter: WIDTH_LOG, default 4, operand width is WIDTH = 1 << WIDTH_LOG bits.
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: rst  input  1  reset; synchronous, active-high.
REQ-004 SHALL have port: go  input  1  start request, sampled only while idle.
REQ-005 SHALL have port: q  input  WIDTH  multiplier (quotient operand).
REQ-006 SHALL have port: b  input  WIDTH  multiplicand (divisor operand).
REQ-007 SHALL have port: r  input  WIDTH  addend (remainder operand).
REQ-008 SHALL have port: ready  output  1  registered; high when idle and the result is valid.
REQ-009 SHALL have port: error  output  1  registered; high when the last operation overflowed WIDTH bits.
REQ-010 SHALL have port: res  output  WIDTH  registered; the result q*b + r.

Function
REQ-011 SHALL compute res = q*b + r as the inverse of divmod, so that a = div*b + mod.
- The addition is unsigned.
- The computation is sequential shift-and-add, with one multiplier bit per cycle.
REQ-012 SHALL implement states IDLE, MUL and ERROR; ready = (state is IDLE or ERROR); error = (state is ERROR).
REQ-013 SHALL, in IDLE or ERROR, start an operation when go=1 at a rising edge, with these registered actions:
- acc <= zero-extended r (2*WIDTH bits);
- mcand <= zero-extended b (2*WIDTH bits);
- mplier <= q;
- count <= 0;
- state <= MUL.
REQ-014 SHALL leave all state unchanged in IDLE or ERROR when go=0; res and error hold their last values.
REQ-015 SHALL, on each MUL cycle, perform these registered actions:
- if mplier[0], acc <= acc + mcand;
- mcand <= mcand << 1;
- mplier <= mplier >> 1;
- count <= count + 1.
REQ-016 SHALL end MUL after the cycle in which count == WIDTH-1, giving a fixed latency with ready low for exactly WIDTH cycles.
REQ-017 SHALL, on the final MUL edge, do the following:
- go to ERROR if the upper WIDTH bits of the final acc are nonzero, else go to IDLE;
- load res with the low WIDTH bits of the final acc.
REQ-018 SHALL treat res as undefined (X permitted) while error=1.
REQ-019 SHALL ignore go while in MUL; the operands are not re-sampled.
REQ-020 SHALL accept go on the same edge at which ready is observed high, allowing back-to-back operations with one idle cycle.
REQ-021 SHALL sample q, b and r only at the start edge; operand changes during MUL have no effect.
REQ-022 SHALL treat b=0 or q=0 as legal, giving res=r and error=0.
REQ-023 SHALL never overflow internally: acc is 2*WIDTH bits and (2^W-1)^2 + 2^W-1 < 2^(2W).

Reset
REQ-024 SHALL, on rst=1 at a rising edge, set state to IDLE, ready=1 and error=0; res, acc, mcand, mplier and count become undefined.
REQ-025 SHALL abort any MUL in progress on rst with no result produced, and rst SHALL take priority over go.

Configuration
REQ-026 SHALL support macro MULADD_EARLY_EXIT_EN.
- When defined, MUL also ends after the cycle whose shifted mplier becomes zero.
- The iteration count is therefore max(1, msb_index(q)+1), and q=0 takes 1 cycle.
- When undefined, the latency is always WIDTH cycles per REQ-016.
- Results and error are identical in both builds.

Structure
REQ-027 SHALL place the state encodings (IDLE=2'd0, MUL=2'd1, ERROR=2'd2) in the shared defines header, alongside the divmod encodings.
REQ-028 SHALL keep combinational next-state logic separate from a single registered update block.
REQ-029 SHALL instantiate sub-module prio_enc on q for the latched iteration limit, only when MULADD_EARLY_EXIT_EN is defined.

Verification (WIDTH_LOG=4)
REQ-030 SHALL cover: q=3, b=5, r=2, go pulse -> res=17, error=0.
- ready is low for 16 cycles in the default build and 2 cycles with MULADD_EARLY_EXIT_EN.
REQ-031 SHALL cover: q=0, b=0xFFFF, r=7 -> res=7, error=0 (1 cycle low with early exit).
REQ-032 SHALL cover: q=0xFFFF, b=1, r=1 -> error=1, ready=1; a following go with q=2, b=2, r=0 -> res=4, error=0.
REQ-033 SHALL cover: divmod round-trip a=1000, b=7 -> div=142, mod=6; then muladd(142, 7, 6) -> res=1000.
REQ-034 SHALL cover: go held high continuously with operands changing during MUL -> each result matches the operands sampled at the start edge only.
REQ-035 SHALL cover: rst asserted 3 cycles into MUL -> next cycle ready=1, error=0; a fresh go with q=0x100, b=0x100, r=0 -> error=1.

Source files
------------

// File: rtl/muladd_pkg.sv
// ============================================================================
// Module : muladd_pkg
// Brief  : Shared state encodings for the muladd and divmod blocks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package muladd_pkg;

    localparam logic [1:0] c_MULADD_IDLE  = 2'd0;
    localparam logic [1:0] c_MULADD_MUL   = 2'd1;
    localparam logic [1:0] c_MULADD_ERROR = 2'd2;

    localparam logic [1:0] c_DIVMOD_IDLE  = 2'd0;
    localparam logic [1:0] c_DIVMOD_DIV   = 2'd1;
    localparam logic [1:0] c_DIVMOD_ERROR = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = c_MULADD_IDLE,
        ST_MUL   = c_MULADD_MUL,
        ST_ERROR = c_MULADD_ERROR
    } muladd_state_e;

endpackage

`default_nettype wire

// File: rtl/muladd_prio_enc.sv
// ============================================================================
// Module : prio_enc
// Brief  : Index of the most significant set bit; built only when
//          MULADD_EARLY_EXIT_EN is defined.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

`ifdef MULADD_EARLY_EXIT_EN
module prio_enc #(
    parameter int WIDTH = 16,
    parameter int IDX_W = 4
) (
    input  logic [WIDTH-1:0] i_data,
    output logic [IDX_W-1:0] o_idx,
    output logic             o_valid
);

    // Ascending scan so the highest set bit wins.
    always_comb begin
        o_idx   = '0;
        o_valid = 1'b0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_data[i]) begin
                o_idx   = IDX_W'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule
`endif

`default_nettype wire

// File: rtl/muladd.sv
// ============================================================================
// Module : muladd
// Brief  : Sequential shift-and-add res = q*b + r (inverse of divmod).
//          MULADD_EARLY_EXIT_EN stops once the remaining multiplier is zero.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module muladd
    import muladd_pkg::*;
#(
    parameter int  WIDTH_LOG = 4,
    localparam int WIDTH     = 1 << WIDTH_LOG
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             go,
    input  logic [WIDTH-1:0] q,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] r,
    output logic             ready,
    output logic             error,
    output logic [WIDTH-1:0] res
);

    muladd_state_e          r_state, w_state_nxt;
    logic [2*WIDTH-1:0]     r_acc, w_acc_nxt, w_acc_step;
    logic [2*WIDTH-1:0]     r_mcand, w_mcand_nxt;
    logic [WIDTH-1:0]       r_mplier, w_mplier_nxt;
    logic [WIDTH_LOG-1:0]   r_count, w_count_nxt;
    logic [WIDTH-1:0]       r_res, w_res_nxt;
    logic                   r_ready;
    logic                   r_error;
    logic [WIDTH_LOG-1:0]   w_last;
    logic [WIDTH_LOG-1:0]   w_last_nxt;

`ifdef MULADD_EARLY_EXIT_EN
    logic [WIDTH_LOG-1:0]   r_last;
    logic [WIDTH_LOG-1:0]   w_enc_idx;
    logic                   w_enc_valid;

    prio_enc #(
        .WIDTH (WIDTH),
        .IDX_W (WIDTH_LOG)
    ) u_prio_enc (
        .i_data  (q),
        .o_idx   (w_enc_idx),
        .o_valid (w_enc_valid)
    );

    // q = 0 still runs a single iteration.
    assign w_last_nxt = w_enc_valid ? w_enc_idx : '0;
    assign w_last     = r_last;
`else
    assign w_last_nxt = WIDTH_LOG'(WIDTH - 1);
    assign w_last     = WIDTH_LOG'(WIDTH - 1);
`endif

    assign w_acc_step = r_mplier[0] ? (r_acc + r_mcand) : r_acc;

    always_comb begin
        w_state_nxt  = r_state;
        w_acc_nxt    = r_acc;
        w_mcand_nxt  = r_mcand;
        w_mplier_nxt = r_mplier;
        w_count_nxt  = r_count;
        w_res_nxt    = r_res;
        case (r_state)
            ST_IDLE, ST_ERROR: begin
                if (go) begin
                    w_acc_nxt    = {{WIDTH{1'b0}}, r};
                    w_mcand_nxt  = {{WIDTH{1'b0}}, b};
                    w_mplier_nxt = q;
                    w_count_nxt  = '0;
                    w_state_nxt  = ST_MUL;
                end
            end
            ST_MUL: begin
                w_acc_nxt    = w_acc_step;
                w_mcand_nxt  = r_mcand << 1;
                w_mplier_nxt = r_mplier >> 1;
                w_count_nxt  = r_count + WIDTH_LOG'(1);
                if (r_count == w_last) begin
                    w_res_nxt   = w_acc_step[WIDTH-1:0];
                    w_state_nxt = (|w_acc_step[2*WIDTH-1:WIDTH]) ? ST_ERROR : ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
            r_error <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_ready  <= (w_state_nxt != ST_MUL);
            r_error  <= (w_state_nxt == ST_ERROR);
            r_acc    <= w_acc_nxt;
            r_mcand  <= w_mcand_nxt;
            r_mplier <= w_mplier_nxt;
            r_count  <= w_count_nxt;
            r_res    <= w_res_nxt;
`ifdef MULADD_EARLY_EXIT_EN
            if ((r_state != ST_MUL) && go) begin
                r_last <= w_last_nxt;
            end
`endif
        end
    end

`ifndef MULADD_EARLY_EXIT_EN
    logic w_unused;
    assign w_unused = ^w_last_nxt;
`endif

    assign ready = r_ready;
    assign error = r_error;
    assign res   = r_res;

endmodule

`default_nettype wire
